// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes (identical to the control decoder's),
// fetch sequencer state encoding, and a branch-offset helper.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_STALL = 6'b000110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_NOP   = 6'b111111;

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } fetch_state_e;

  // Word-aligned, sign-extended branch displacement.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch bus.
//   imem_req   : fetch request, held until imem_ready
//   imem_addr  : byte address of the fetch
//   imem_ready : response strobe, imem_rdata valid in that cycle
//   imem_rdata : fetched instruction word
// master = sequencer side, slave = memory agent side.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ready, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_sequencer_next_pc_calc.sv
// Combinational next-PC selection.
//   pc, instr                     : current instruction and its address
//   jump, branch_on_eq/neq, zero  : decoder controls and ALU flag
//   next_pc                       : jump target, branch target or pc+4
// Decoder branch controls are re-qualified by opcode because the decoder
// raises branch_on_eq for non-branch opcodes as well. Jump wins over branch.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        jump,
  input  logic        branch_on_eq,
  input  logic        branch_on_neq,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic [5:0]  op;
  logic [31:0] pc4, br_target, jmp_target;
  logic        take_jump, take_br;

  assign op         = instr[31:26];
  assign pc4        = pc + 32'd4;
  assign br_target  = pc4 + branch_offset(instr[15:0]);
  assign jmp_target = {pc4[31:28], instr[25:0], 2'b00};
  assign take_jump  = jump && (op == OP_J);
  assign take_br    = ((op == OP_BEQ) && branch_on_eq  &&  zero) ||
                      ((op == OP_BNE) && branch_on_neq && !zero);

  always_comb begin
    next_pc = pc4;
    if (take_jump)    next_pc = jmp_target;
    else if (take_br) next_pc = br_target;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Non-pipelined instruction fetch / next-PC sequencer.
//   clk, rst       : clock, synchronous active-high reset
//   imem           : fetch bus (master)
//   instr/opcode/funct, instr_valid : instruction issued to decoder/datapath
//   ex_done, zero  : datapath completion and ALU zero flag
//   branch_on_eq/branch_on_neq/jump : decoder controls
//   hold           : freeze all state (imem_req keeps its value)
//   pc, instret    : current instruction address, retired count
// One instruction in flight: FETCH until imem_ready, ISSUE until retire.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned STALL_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  fetch_sequencer_if.master   imem,
  output logic [31:0]         instr,
  output logic                instr_valid,
  output logic [5:0]          opcode,
  output logic [5:0]          funct,
  input  logic                ex_done,
  input  logic                zero,
  input  logic                branch_on_eq,
  input  logic                branch_on_neq,
  input  logic                jump,
  input  logic                hold,
  output logic [31:0]         pc,
  output logic [31:0]         instret
);

  localparam logic [7:0] STALL_LAST = 8'(STALL_CYCLES);

  fetch_state_e state;
  logic [7:0]   stall_cnt;
  logic [31:0]  next_pc;
  logic         retire;

  assign opcode         = instr[31:26];
  assign funct          = instr[5:0];
  assign imem.imem_addr = pc;

  next_pc_calc u_next_pc (
    .pc            (pc),
    .instr         (instr),
    .jump          (jump),
    .branch_on_eq  (branch_on_eq),
    .branch_on_neq (branch_on_neq),
    .zero          (zero),
    .next_pc       (next_pc)
  );

  // Retire condition while issuing; stall_cnt already reads 1 in the first
  // ISSUE cycle of a STALL, so it holds exactly STALL_CYCLES cycles.
  always_comb begin
    retire = 1'b0;
    case (opcode)
      OP_NOP:   retire = 1'b1;
      OP_STALL: retire = (stall_cnt == STALL_LAST);
      default:  retire = ex_done;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      instr         <= '0;
      instr_valid   <= 1'b0;
      imem.imem_req <= 1'b0;
      stall_cnt     <= '0;
      instret       <= '0;
    end else if (!hold) begin
      case (state)
        FETCH: begin
          // req comes up one cycle after reset; afterwards retire re-arms it
          if (!imem.imem_req) begin
            imem.imem_req <= 1'b1;
          end else if (imem.imem_ready) begin
            instr         <= imem.imem_rdata;
            instr_valid   <= 1'b1;
            imem.imem_req <= 1'b0;
            stall_cnt     <= (imem.imem_rdata[31:26] == OP_STALL) ? 8'd1 : 8'd0;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (retire) begin
            pc            <= next_pc;
            instret       <= instret + 32'd1;
            instr_valid   <= 1'b0;
            stall_cnt     <= '0;
            imem.imem_req <= 1'b1;
            state         <= FETCH;
          end else if (opcode == OP_STALL) begin
            stall_cnt <= stall_cnt + 8'd1;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
